// File: rtl/mii_dbg_pkg.sv
// Shared definitions for the MII receive debug trigger path: FSM states,
// MII framing nibbles and the masked byte-compare helper.
package mii_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_MATCH    = 3'd2,
    ST_BODY     = 3'd3,
    ST_DROP     = 3'd4
  } rx_state_e;

  localparam logic [3:0] PREAMBLE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB      = 4'hD;

  // A byte only counts as different when its compare enable is set.
  function automatic logic byte_differs(input logic [7:0] rx_byte,
                                        input logic [7:0] pat_byte,
                                        input logic       care);
    return care & (rx_byte != pat_byte);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that increments on request and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] out
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Saturating count register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out <= {CNT_W{1'b0}};
    end else if (inc && (out != CNT_MAX)) begin
      out <= out + CNT_W'(1);
    end else begin
      out <= out;
    end
  end

endmodule

// File: rtl/mii_rx_trigger_gen.sv
// MII RX nibble deserialiser: finds preamble/SFD, compares the leading frame
// bytes against a masked pattern and pulses the IICE external trigger.
module mii_rx_trigger_gen
  import mii_dbg_pkg::*;
#(
  parameter int PATTERN_BYTES = 6,
  parameter int CNT_W         = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rxdv,
  input  logic                       rxer,
  input  logic [3:0]                 rxd,
  input  logic                       sampler_ready,
  input  logic                       cfg_en,
  input  logic                       cfg_on_error,
  input  logic [8*PATTERN_BYTES-1:0] cfg_pattern,
  input  logic [PATTERN_BYTES-1:0]   cfg_mask,
  output logic                       trig_out,
  output logic [CNT_W-1:0]           frame_cnt,
  output logic [CNT_W-1:0]           err_cnt,
  output logic [CNT_W-1:0]           miss_cnt
);

  localparam logic [2:0] LAST_IDX = 3'(PATTERN_BYTES - 1);

  logic        rxdv_r;
  logic        rxer_r;
  logic [3:0]  rxd_r;
  logic        valid_r;
  logic        armed_r;
  rx_state_e   state_r;
  rx_state_e   state_s;
  logic [2:0]  byte_idx_r;
  logic [2:0]  byte_idx_s;
  logic        phase_r;
  logic        phase_s;
  logic [3:0]  low_nib_r;
  logic [3:0]  low_nib_s;
  logic        mismatch_r;
  logic        mismatch_s;
  logic        frame_inc_s;
  logic        err_evt_s;
  logic        match_s;
  logic        trig_evt_s;
  logic        trig_s;
  logic        miss_inc_s;
  logic        trig_out_r;
  logic [7:0]  pat_byte_s;
  logic        care_s;

  // Input capture stage; every decision below uses these copies.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxdv_r <= 1'b0;
      rxer_r <= 1'b0;
      rxd_r  <= 4'h0;
    end else begin
      rxdv_r <= rxdv;
      rxer_r <= rxer;
      rxd_r  <= rxd;
    end
  end

  // Arm only after a truly sampled idle line, so a frame cut by reset is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      valid_r <= 1'b1;
      armed_r <= armed_r | (valid_r & ~rxdv_r);
    end
  end

  // Select the pattern byte and compare enable for the current byte index.
  always_comb begin
    pat_byte_s = 8'h00;
    care_s     = 1'b0;
    for (int k = 0; k < PATTERN_BYTES; k++) begin
      pat_byte_s = (byte_idx_r == 3'(k)) ? cfg_pattern[8*k +: 8] : pat_byte_s;
      care_s     = (byte_idx_r == 3'(k)) ? cfg_mask[k] : care_s;
    end
  end

  // Next-state and event decode.
  always_comb begin
    state_s     = state_r;
    byte_idx_s  = byte_idx_r;
    phase_s     = phase_r;
    low_nib_s   = low_nib_r;
    mismatch_s  = mismatch_r;
    frame_inc_s = 1'b0;
    err_evt_s   = 1'b0;
    match_s     = 1'b0;
    if (!rxdv_r) begin
      state_s = ST_IDLE;
    end else if (rxer_r && (state_r inside {ST_PREAMBLE, ST_MATCH, ST_BODY})) begin
      // Leaving for DROP guarantees one error count per frame.
      err_evt_s = 1'b1;
      state_s   = ST_DROP;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (armed_r && (rxd_r == PREAMBLE_NIB)) begin
            state_s = ST_PREAMBLE;
          end else begin
            state_s = ST_DROP;
          end
        end
        ST_PREAMBLE: begin
          if (rxd_r == PREAMBLE_NIB) begin
            state_s = ST_PREAMBLE;
          end else if (rxd_r == SFD_NIB) begin
            state_s     = ST_MATCH;
            byte_idx_s  = 3'd0;
            phase_s     = 1'b0;
            mismatch_s  = 1'b0;
            frame_inc_s = 1'b1;
          end else begin
            state_s = ST_DROP;
          end
        end
        ST_MATCH: begin
          if (!phase_r) begin
            low_nib_s = rxd_r;
            phase_s   = 1'b1;
          end else begin
            phase_s    = 1'b0;
            mismatch_s = mismatch_r | byte_differs({rxd_r, low_nib_r}, pat_byte_s, care_s);
            if (byte_idx_r == LAST_IDX) begin
              match_s = ~mismatch_s;
              state_s = ST_BODY;
            end else begin
              byte_idx_s = byte_idx_r + 3'd1;
            end
          end
        end
        ST_BODY: state_s = ST_BODY;
        ST_DROP: state_s = ST_DROP;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  assign trig_evt_s = cfg_en & (match_s | (err_evt_s & cfg_on_error));
  assign trig_s     = trig_evt_s & sampler_ready;
  assign miss_inc_s = trig_evt_s & ~sampler_ready;

  // FSM and byte-compare context registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      byte_idx_r <= 3'd0;
      phase_r    <= 1'b0;
      low_nib_r  <= 4'h0;
      mismatch_r <= 1'b0;
      trig_out_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      byte_idx_r <= byte_idx_s;
      phase_r    <= phase_s;
      low_nib_r  <= low_nib_s;
      mismatch_r <= mismatch_s;
      trig_out_r <= trig_s;
    end
  end

  assign trig_out = trig_out_r;

  sat_counter #(.CNT_W(CNT_W)) u_frame_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (frame_inc_s),
    .out   (frame_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_evt_s),
    .out   (err_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (miss_inc_s),
    .out   (miss_cnt)
  );

endmodule

// File: tb/tb_mii_rx_trigger_gen.sv
// Bench for mii_rx_trigger_gen: directed frames plus random frames checked
// against a frame-level parser model of the trigger and statistics rules.
module tb_mii_rx_trigger_gen;

  localparam int PB  = 6;
  localparam int CW  = 8;   // narrow counters keep the saturation run short
  localparam int SAT = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic            rxdv;
  logic            rxer;
  logic [3:0]      rxd;
  logic            sampler_ready;
  logic            cfg_en;
  logic            cfg_on_error;
  logic [8*PB-1:0] cfg_pattern;
  logic [PB-1:0]   cfg_mask;
  logic            trig_out;
  logic [CW-1:0]   frame_cnt;
  logic [CW-1:0]   err_cnt;
  logic [CW-1:0]   miss_cnt;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int exp_frame = 0;
  int exp_err = 0;
  int exp_miss = 0;

  logic [3:0] nib_q[$];
  bit         er_q[$];
  int         drv_q[$];
  int         trig_q[$];
  int         exp_trig_q[$];

  mii_rx_trigger_gen #(.PATTERN_BYTES(PB), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .rxdv          (rxdv),
    .rxer          (rxer),
    .rxd           (rxd),
    .sampler_ready (sampler_ready),
    .cfg_en        (cfg_en),
    .cfg_on_error  (cfg_on_error),
    .cfg_pattern   (cfg_pattern),
    .cfg_mask      (cfg_mask),
    .trig_out      (trig_out),
    .frame_cnt     (frame_cnt),
    .err_cnt       (err_cnt),
    .miss_cnt      (miss_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (trig_out === 1'b1) trig_q.push_back(cyc);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_nib(input logic [3:0] n, input bit e);
    nib_q.push_back(n);
    er_q.push_back(e);
  endtask

  task automatic push_byte(input logic [7:0] b);
    push_nib(b[3:0], 1'b0);
    push_nib(b[7:4], 1'b0);
  endtask

  task automatic push_preamble();
    repeat (7) push_byte(8'h55);
    push_byte(8'hD5);
  endtask

  task automatic push_da(input logic [8*PB-1:0] da);
    for (int b = 0; b < PB; b++) push_byte(da[8*b +: 8]);
  endtask

  task automatic drive_nibs(input int from, input int to);
    for (int i = from; i < to; i++) begin
      @(posedge clk); #1;
      rxdv = 1'b1;
      rxd  = nib_q[i];
      rxer = er_q[i];
      drv_q.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rxdv = 1'b0;
      rxer = 1'b0;
      rxd  = 4'h0;
    end
  endtask

  task automatic sat_inc(inout int c);
    if (c < SAT) c++;
  endtask

  // Trigger seen two cycles after the deciding nibble was on the pins.
  task automatic fire(input int idx);
    if (sampler_ready) exp_trig_q.push_back(drv_q[idx] + 2);
    else sat_inc(exp_miss);
  endtask

  task automatic err_event(input int idx);
    sat_inc(exp_err);
    if (cfg_en && cfg_on_error) fire(idx);
  endtask

  // Frame-level parse of the nibble list that was just driven.
  task automatic model();
    int n;
    int i;
    int lo;
    bit mism;
    logic [7:0] rb;
    logic [7:0] pb;
    n = nib_q.size();
    if (n == 0 || nib_q[0] != 4'h5) return;
    i = 1;
    while (i < n && !er_q[i] && nib_q[i] == 4'h5) i++;
    if (i >= n) return;
    if (er_q[i]) begin err_event(i); return; end
    if (nib_q[i] != 4'hD) return;
    sat_inc(exp_frame);
    mism = 1'b0;
    for (int b = 0; b < PB; b++) begin
      lo = i + 1 + 2 * b;
      if (lo >= n) return;
      if (er_q[lo]) begin err_event(lo); return; end
      if (lo + 1 >= n) return;
      if (er_q[lo+1]) begin err_event(lo + 1); return; end
      rb = {nib_q[lo+1], nib_q[lo]};
      pb = cfg_pattern[8*b +: 8];
      if (cfg_mask[b] && rb != pb) mism = 1'b1;
    end
    if (!mism && cfg_en) fire(i + 2 * PB);
    for (int j = i + 2 * PB + 1; j < n; j++) begin
      if (er_q[j]) begin err_event(j); return; end
    end
  endtask

  task automatic clear_frame();
    nib_q.delete();
    er_q.delete();
    drv_q.delete();
  endtask

  task automatic do_frame(input int gap);
    drive_nibs(0, nib_q.size());
    idle(gap);
    model();
    clear_frame();
  endtask

  task automatic check_all(input string tag);
    int m;
    idle(4);
    check($sformatf("%s_pulses", tag), trig_q.size(), exp_trig_q.size());
    m = (trig_q.size() < exp_trig_q.size()) ? trig_q.size() : exp_trig_q.size();
    for (int k = 0; k < m; k++) check($sformatf("%s_pulse_cyc%0d", tag, k), trig_q[k], exp_trig_q[k]);
    check($sformatf("%s_frame_cnt", tag), frame_cnt, exp_frame);
    check($sformatf("%s_err_cnt", tag), err_cnt, exp_err);
    check($sformatf("%s_miss_cnt", tag), miss_cnt, exp_miss);
    trig_q.delete();
    exp_trig_q.delete();
  endtask

  task automatic rand_frame();
    int pre;
    int kind;
    int pay;
    int keep;
    logic [7:0] bb;
    pre  = $urandom_range(15, 1);
    kind = $urandom_range(19, 0);
    if (kind == 0) push_nib(4'($urandom_range(15, 0)), 1'b0);
    for (int i = 0; i < pre; i++) push_nib(4'h5, 1'b0);
    if (kind == 1) push_nib(4'h7, 1'b0);
    push_nib(4'hD, 1'b0);
    for (int b = 0; b < PB; b++) begin
      bb = cfg_pattern[8*b +: 8];
      if ($urandom_range(5, 0) == 0) bb = bb ^ 8'($urandom_range(255, 1));
      push_byte(bb);
    end
    pay = $urandom_range(6, 0);
    for (int b = 0; b < pay; b++) push_byte(8'($urandom));
    if (kind == 2) begin
      keep = $urandom_range(nib_q.size() - 1, 1);
      while (nib_q.size() > keep) begin
        void'(nib_q.pop_back());
        void'(er_q.pop_back());
      end
    end
    if ($urandom_range(7, 0) == 0) er_q[$urandom_range(nib_q.size() - 1, 0)] = 1'b1;
  endtask

  localparam logic [8*PB-1:0] DA = 48'h554433221100;

  initial begin
    logic [63:0] r64;
    reset = 1'b1; rxdv = 1'b0; rxer = 1'b0; rxd = 4'h0;
    sampler_ready = 1'b1; cfg_en = 1'b1; cfg_on_error = 1'b0;
    cfg_pattern = DA; cfg_mask = 6'h3F;
    repeat (3) @(posedge clk);
    #1;
    check("rst_trig", trig_out, 1'b0);
    check("rst_frame", frame_cnt, 0);
    check("rst_err", err_cnt, 0);
    check("rst_miss", miss_cnt, 0);
    @(negedge clk); reset = 1'b0;
    idle(3);

    // Matching frame.
    push_preamble(); push_da(DA); push_byte(8'hAB); push_byte(8'hCD);
    do_frame(2); check_all("match");

    // Byte 3 differs, then same frame with byte 3 masked off.
    push_preamble(); push_da(48'h554434221100); push_byte(8'h01);
    do_frame(2); check_all("byte3_diff");
    cfg_mask = 6'h37;
    push_preamble(); push_da(48'h554434221100); push_byte(8'h01);
    do_frame(2); check_all("byte3_masked");
    cfg_mask = 6'h3F;

    // rxer during DA byte 2, with and without error triggering.
    cfg_on_error = 1'b1;
    push_preamble(); push_da(DA); er_q[16 + 4] = 1'b1;
    do_frame(2); check_all("err_trig");
    cfg_on_error = 1'b0;
    push_preamble(); push_da(DA); er_q[16 + 5] = 1'b1;
    do_frame(2); check_all("err_notrig");

    // rxer on the final DA nibble: error takes precedence over the match.
    cfg_on_error = 1'b1;
    push_preamble(); push_da(DA); er_q[16 + 2*PB - 1] = 1'b1;
    do_frame(2); check_all("err_last_nib");
    cfg_on_error = 1'b0;

    // Sampler not ready, then runt frame.
    sampler_ready = 1'b0;
    push_preamble(); push_da(DA);
    do_frame(2); check_all("miss");
    sampler_ready = 1'b1;
    push_preamble(); push_byte(8'h00); push_byte(8'h11); push_byte(8'h22);
    do_frame(2); check_all("runt");

    // Corrupt preamble, then good frame after a single idle cycle.
    for (int i = 0; i < 6; i++) push_nib(4'h5, 1'b0);
    push_nib(4'h7, 1'b0); push_nib(4'h5, 1'b0); push_nib(4'hD, 1'b0); push_da(DA);
    do_frame(1);
    push_preamble(); push_da(DA);
    do_frame(2); check_all("bad_pre_then_good");

    // Randomized frames and configurations.
    for (int f = 0; f < 150; f++) begin
      if (f % 16 == 0) begin
        r64 = {$urandom, $urandom};
        cfg_pattern = r64[8*PB-1:0];
      end
      cfg_en        = ($urandom_range(7, 0) != 0);
      cfg_on_error  = 1'($urandom_range(1, 0));
      sampler_ready = ($urandom_range(5, 0) != 0);
      cfg_mask      = ($urandom_range(3, 0) == 0) ? 6'($urandom) : 6'h3F;
      rand_frame();
      do_frame($urandom_range(3, 1));
      check_all($sformatf("rand%0d", f));
    end

    // Saturate the frame counter with minimal frames.
    cfg_en = 1'b1; cfg_pattern = DA; cfg_mask = 6'h3F; sampler_ready = 1'b1;
    for (int f = 0; f < SAT + 5; f++) begin
      push_nib(4'h5, 1'b0); push_nib(4'hD, 1'b0);
      do_frame(1);
    end
    check_all("saturate");
    check("sat_frame_all_ones", frame_cnt, SAT);

    // Reset in the middle of a frame that would otherwise match.
    push_preamble(); push_da(DA); push_byte(8'h42);
    drive_nibs(0, 6);
    #2 reset = 1'b1;
    #1;
    check("midrst_trig", trig_out, 1'b0);
    check("midrst_frame", frame_cnt, 0);
    check("midrst_err", err_cnt, 0);
    check("midrst_miss", miss_cnt, 0);
    exp_frame = 0; exp_err = 0; exp_miss = 0;
    @(negedge clk); reset = 1'b0;
    drive_nibs(6, nib_q.size());
    idle(1);
    clear_frame();
    check_all("midrst_rest");
    push_preamble(); push_da(DA);
    do_frame(2); check_all("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
